pipe_cla_adder: RTL and testbench

PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

---
 rtl/cla_pkg.sv | 22 ++
 rtl/cla_group4.sv | 31 +++
 rtl/pipe_cla_adder.sv | 158 +++++++++++++++
 tb/tb_pipe_cla_adder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
// Groups are always 4 bits wide; the group count follows from the operand width.
package cla_pkg;

    localparam int GROUP_W = 4;

    function automatic int num_groups(input int width);
        return width / GROUP_W;
    endfunction

    // Returns {group propagate, group generate} for one nibble pair.
    function automatic logic [1:0] group_pg(input logic [GROUP_W-1:0] a,
                                            input logic [GROUP_W-1:0] b);
        logic [GROUP_W-1:0] p;
        logic [GROUP_W-1:0] g;
        p = a | b;
        g = a & b;
        return {&p,
                g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])};
    endfunction

endpackage

// File: rtl/cla_group4.sv
// One 4-bit carry-lookahead group: sum bits from the group carry-in plus the
// group propagate/generate pair used by the second-level lookahead.
module cla_group4
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] i_a,
    input  logic [GROUP_W-1:0] i_b,
    input  logic               i_ci,
    output logic [GROUP_W-1:0] o_s,
    output logic               o_p,
    output logic               o_g
);

    logic [GROUP_W-1:0] w_p;
    logic [GROUP_W-1:0] w_g;
    logic [GROUP_W-1:0] w_c;

    assign w_p = i_a | i_b;
    assign w_g = i_a & i_b;

    // Flat in-group lookahead: every carry is two logic levels from the inputs.
    assign w_c[0] = i_ci;
    assign w_c[1] = w_g[0] | (w_p[0] & i_ci);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_ci);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_ci);

    assign o_s        = i_a ^ i_b ^ w_c;
    assign {o_p, o_g} = group_pg(i_a, i_b);

endmodule

// File: rtl/pipe_cla_adder.sv
// Two-stage valid/ready pipelined carry-lookahead adder.
// Define CLA_SUB_EN to make the sub input select a - b (two's complement).
module pipe_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NG = num_groups(WIDTH);

    generate
        if ((WIDTH % GROUP_W) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_width_check
            $error("pipe_cla_adder: WIDTH=%0d must be a multiple of 4 in 4..64", WIDTH);
        end
    endgenerate

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_cin;
    logic [NG-1:0]    r_s1_gp;
    logic [NG-1:0]    r_s1_gg;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;
    logic [NG-1:0]    w_in_gp;
    logic [NG-1:0]    w_in_gg;
    logic [NG:0]      w_gc;
    logic             w_term;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_c_msb;
    logic             w_ovf;
    logic             w_in_fire;
    logic             w_s2_load;
    logic [NG-1:0]    w_s2_gp_unused;
    logic [NG-1:0]    w_s2_gg_unused;

`ifdef CLA_SUB_EN
    assign w_b_eff   = sub ? ~b : b;
    assign w_cin_eff = sub | cin;
`else
    logic w_sub_unused;
    assign w_sub_unused = sub;
    assign w_b_eff      = b;
    assign w_cin_eff    = cin;
`endif

    // Handshake: S1 frees up whenever it can move into S2 this cycle.
    assign w_s2_load = r_s1_valid && (!r_out_valid || out_ready);
    assign in_ready  = !r_s1_valid || !r_out_valid || out_ready;
    assign w_in_fire = in_valid && in_ready;

    generate
        for (genvar gi = 0; gi < NG; gi++) begin : g_in_pg
            assign {w_in_gp[gi], w_in_gg[gi]} =
                group_pg(a[gi*GROUP_W +: GROUP_W], w_b_eff[gi*GROUP_W +: GROUP_W]);
        end
    endgenerate

    // Second-level lookahead: each group carry is a flat sum of products over
    // the registered group P/G and the effective carry-in.
    always_comb begin
        w_gc   = '0;
        w_term = 1'b0;
        for (int j = 0; j <= NG; j++) begin
            w_term = r_s1_cin;
            for (int k = 0; k < j; k++) begin
                w_term = w_term & r_s1_gp[k];
            end
            w_gc[j] = w_term;
            for (int k = 0; k < j; k++) begin
                w_term = r_s1_gg[k];
                for (int m = k + 1; m < j; m++) begin
                    w_term = w_term & r_s1_gp[m];
                end
                w_gc[j] = w_gc[j] | w_term;
            end
        end
    end

    // The group adders also report P/G; the registered copy already feeds the lookahead.
    generate
        for (genvar gi = 0; gi < NG; gi++) begin : g_group
            cla_group4 u_group (
                .i_a  (r_s1_a[gi*GROUP_W +: GROUP_W]),
                .i_b  (r_s1_b[gi*GROUP_W +: GROUP_W]),
                .i_ci (w_gc[gi]),
                .o_s  (w_sum[gi*GROUP_W +: GROUP_W]),
                .o_p  (w_s2_gp_unused[gi]),
                .o_g  (w_s2_gg_unused[gi])
            );
        end
    endgenerate

    assign w_cout  = w_gc[NG];
    assign w_c_msb = r_s1_a[WIDTH-1] ^ r_s1_b[WIDTH-1] ^ w_sum[WIDTH-1];
    assign w_ovf   = w_c_msb ^ w_cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_cin    <= 1'b0;
            r_s1_gp     <= '0;
            r_s1_gg     <= '0;
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
                r_s1_a     <= a;
                r_s1_b     <= w_b_eff;
                r_s1_cin   <= w_cin_eff;
                r_s1_gp    <= w_in_gp;
                r_s1_gg    <= w_in_gg;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s2_load) begin
                r_out_valid <= 1'b1;
                r_sum       <= w_sum;
                r_cout      <= w_cout;
                r_ovf       <= w_ovf;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Self-checking bench for pipe_cla_adder (WIDTH=16): directed cases, backpressure,
// mid-flight reset and a randomized run against an arithmetic reference model.
module tb_pipe_cla_adder;

    localparam int W = 16;
`ifdef CLA_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    logic [W+1:0] exp_q[$];

    pipe_cla_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer addition, result packed as {ovf, cout, sum}.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                             input logic tcin, input logic tsub);
        logic [W-1:0] bb;
        logic         cc;
        logic [W:0]   full;
        logic [W-1:0] s;
        logic         ov;
        bb = tb_;
        cc = tcin;
        if (SUB_EN && tsub) begin
            bb = ~tb_;
            cc = 1'b1;
        end
        full = {1'b0, ta} + {1'b0, bb} + {{W{1'b0}}, cc};
        s    = full[W-1:0];
        ov   = (ta[W-1] == bb[W-1]) && (s[W-1] != ta[W-1]);
        return {ov, full[W], s};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({out_valid, cout, ovf, sum} !== {3'b000, {W{1'b0}}}) begin
                errors++;
                $display("FAIL reset_state: got out_valid=%b cout=%b ovf=%b sum=%h, need 0 0 0 0000",
                         out_valid, cout, ovf, sum);
            end
        end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, need 1 0", in_ready, out_valid);
        end
        $display("txn reset: in_ready=%b out_valid=%b", in_ready, out_valid);
        step();
    endtask

    task automatic test_directed(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                 input logic tcin, input logic tsub,
                                 input logic [W-1:0] es, input logic ec, input logic eo);
        a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_in_ready: got %b, need 1", name, in_ready);
        end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_early: out_valid=%b one cycle after accept, need 0", name, out_valid);
        end
        step();
        @(negedge clk);
        checks++;
        if ({out_valid, sum, cout, ovf} !== {1'b1, es, ec, eo}) begin
            errors++;
            $display("FAIL %s_result: got valid=%b sum=%h cout=%b ovf=%b, need 1 %h %b %b",
                     name, out_valid, sum, cout, ovf, es, ec, eo);
        end
        $display("txn %s: a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b",
                 name, ta, tb_, tcin, tsub, sum, cout, ovf);
        step();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp_sum;
        out_ready = 1'b0; in_valid = 1'b1; cin = 1'b0; sub = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            a = W'(i); b = W'(i);
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL bp_accept%0d: in_ready=%b, need 1", i, in_ready);
            end
            step();
        end
        a = 16'd3; b = 16'd3;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({in_ready, out_valid, sum} !== {1'b0, 1'b1, 16'h0002}) begin
                errors++;
                $display("FAIL bp_hold: got in_ready=%b out_valid=%b sum=%h, need 0 1 0002",
                         in_ready, out_valid, sum);
            end
            step();
        end
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            exp_sum = W'(2 * i);
            @(negedge clk);
            checks++;
            if ({out_valid, sum} !== {1'b1, exp_sum} || (i == 1 && in_ready !== 1'b1)) begin
                errors++;
                $display("FAIL bp_drain%0d: got out_valid=%b sum=%h in_ready=%b, need 1 %h", i,
                         out_valid, sum, in_ready, exp_sum);
            end
            $display("txn bp_drain%0d: sum=%h", i, sum);
            step();
            in_valid = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: out_valid=%b, need 0", out_valid);
        end
        step();
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0; in_valid = 1'b1; cin = 1'b0; sub = 1'b0;
        a = 16'h0011; b = 16'h0001;
        step();
        a = 16'h0022;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_full: out_valid=%b in_ready=%b, need 1 0", out_valid, in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sum !== '0) begin
            errors++;
            $display("FAIL mid_async: out_valid=%b sum=%h right after rst_n fall, need 0 0000",
                     out_valid, sum);
        end
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL mid_stale%0d: out_valid=%b in_ready=%b, need 0 1", i, out_valid, in_ready);
            end
            step();
        end
        $display("txn mid_reset: no stale result after release");
    endtask

    task automatic test_random(input int n);
        int           accepted  = 0;
        int           cycles    = 0;
        logic         prev_hold = 1'b0;
        logic [W+1:0] prev_out  = '0;
        logic [W+1:0] exp;
        exp_q.delete();
        while ((accepted < n || exp_q.size() != 0) && cycles < 60000) begin
            in_valid  = (accepted < n) && ($urandom_range(0, 3) != 0);
            a         = W'($urandom);
            b         = W'($urandom);
            cin       = 1'($urandom);
            sub       = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            checks++;
            if (in_ready !== ((exp_q.size() < 2) || out_ready)) begin
                errors++;
                $display("FAIL rnd_in_ready: got %b with %0d in flight out_ready=%b",
                         in_ready, exp_q.size(), out_ready);
            end
            if (prev_hold) begin
                checks++;
                if (out_valid !== 1'b1 || {ovf, cout, sum} !== prev_out) begin
                    errors++;
                    $display("FAIL rnd_stable: got valid=%b out=%h, need 1 %h",
                             out_valid, {ovf, cout, sum}, prev_out);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_extra: result sum=%h with nothing in flight", sum);
                end else begin
                    exp = exp_q.pop_front();
                    if ({ovf, cout, sum} !== exp) begin
                        errors++;
                        $display("FAIL rnd_result: got sum=%h cout=%b ovf=%b, need sum=%h cout=%b ovf=%b",
                                 sum, cout, ovf, exp[W-1:0], exp[W], exp[W+1]);
                    end
                    $display("txn rnd: sum=%h cout=%b ovf=%b", sum, cout, ovf);
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_out  = {ovf, cout, sum};
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_add(a, b, cin, sub));
                accepted++;
            end
            step();
            cycles++;
        end
        in_valid = 1'b0;
        checks++;
        if (accepted != n || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rnd_timeout: accepted %0d of %0d, %0d still pending", accepted, n, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed("wrap",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        test_directed("pos_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        test_directed("neg_ovf",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        test_directed("cin_mix",  16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        test_directed("all_ones", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        test_directed("sub",      16'h0005, 16'h0007, 1'b0, 1'b1,
                      SUB_EN ? 16'hFFFE : 16'h000C, 1'b0, 1'b0);
        test_backpressure();
        test_random(10000);
        test_reset_midflight();
        test_directed("post_rst", 16'h00F0, 16'h0F0F, 1'b0, 1'b0, 16'h0FFF, 1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
